// File: rtl/clk_pkg.sv
// Shared definitions for the slow-clock receive path: the period-meter state encoding,
// the system clock rate, and the saturating event-counter helper.
package clk_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALE   = 2'd2
  } state_t;

  localparam logic [7:0] OVF_MAX = 8'hFF;

  // Event counters stick at full scale instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVF_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with rising-edge detection.
// rise is combinational from the flops; pulse is the same event registered one cycle later.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic rise,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] s;
  logic                   h;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s     <= '0;
      h     <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s     <= {s[SYNC_STAGES-2:0], din};
      h     <= s[SYNC_STAGES-1];
      pulse <= rise;
    end
  end

  assign rise = s[SYNC_STAGES-1] & ~h;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock in clk cycles, emits one-cycle rising-edge
// ticks, and flags a stalled input once the period counter reaches full scale.
module clk_period_meter
  import clk_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clk_in,
  input  logic             en,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             stale,
  output logic [7:0]       ovf_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             vld_nxt;
  logic             stale_nxt;
  logic [7:0]       ovf_nxt;
  logic             rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .clr   (clr),
    .din   (clk_in),
    .rise  (rise),
    .pulse (tick)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      stale      <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      period     <= period_nxt;
      period_vld <= vld_nxt;
      stale      <= stale_nxt;
      ovf_cnt    <= ovf_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = period;
    vld_nxt    = 1'b0;
    stale_nxt  = stale;
    ovf_nxt    = ovf_cnt;

    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      stale_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
          end
        end
        MEASURE: begin
          // A rise landing exactly on full scale is still a valid period, not a stall.
          if (rise) begin
            period_nxt = cnt;
            vld_nxt    = 1'b1;
            cnt_nxt    = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            state_nxt = STALE;
            stale_nxt = 1'b1;
            ovf_nxt   = sat_inc8(ovf_cnt);
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        STALE: begin
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
            stale_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          stale_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter: a time-stamp reference model predicts every output
// each cycle, plus directed checks on latency, stall, full-scale coincidence and async clear.
module tb_clk_period_meter;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clr;
  logic             clk_in;
  logic             en;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             stale;
  logic [7:0]       ovf_cnt;

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .clr        (clr),
    .clk_in     (clk_in),
    .en         (en),
    .tick       (tick),
    .period     (period),
    .period_vld (period_vld),
    .stale      (stale),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remembers the edge index of the last accepted rise and derives the
  // period as a plain time difference; the input history is just a delay line of samples.
  bit  hist[$];
  int  edge_n;
  int  t0;
  bit  armed;
  bit  exp_tick, exp_vld, exp_stale;
  int  exp_period, exp_ovf;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < SYNC + 2; i++) hist.push_back(1'b0);
    edge_n = 0; t0 = 0; armed = 1'b0;
    exp_tick = 1'b0; exp_vld = 1'b0; exp_stale = 1'b0;
    exp_period = 0; exp_ovf = 0;
  endtask

  task automatic model_edge(input bit ci, input bit e);
    bit r;
    edge_n++;
    hist.push_front(ci);
    r = hist[SYNC] && !hist[SYNC+1];
    void'(hist.pop_back());
    exp_tick = r;
    exp_vld  = 1'b0;
    if (!e) begin
      armed     = 1'b0;
      exp_stale = 1'b0;
    end else if (r) begin
      if (armed && !exp_stale) begin
        exp_period = edge_n - t0;
        exp_vld    = 1'b1;
      end
      armed     = 1'b1;
      exp_stale = 1'b0;
      t0        = edge_n;
    end else if (armed && !exp_stale && (edge_n - t0 == MAXC)) begin
      exp_stale = 1'b1;
      if (exp_ovf < 255) exp_ovf++;
    end
  endtask

  task automatic check_all();
    check("tick", tick, exp_tick);
    check("period_vld", period_vld, exp_vld);
    check("period", period, exp_period);
    check("stale", stale, exp_stale);
    check("ovf_cnt", ovf_cnt, exp_ovf);
  endtask

  // One clk cycle: drive at the falling edge, model the rising edge, compare at the next fall.
  task automatic cyc(input bit ci, input bit e);
    clk_in = ci;
    en     = e;
    @(posedge clk);
    model_edge(ci, e);
    @(negedge clk);
    check_all();
  endtask

  task automatic wave(input int hi, input int lo, input bit e);
    repeat (hi) cyc(1'b1, e);
    repeat (lo) cyc(1'b0, e);
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  hi, lo;
    bit  e;

    clk_in = 1'b0;
    en     = 1'b0;
    clr    = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    clr = 1'b0;

    // Steady square wave toggling every 4 cycles.
    repeat (12) wave(4, 4, 1'b1);
    check("period_steady_8", period, 8);

    // Rise-to-tick latency from a quiet low input.
    repeat (8) cyc(1'b0, 1'b1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cyc(1'b1, 1'b1);
      if (tick === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("tick_latency", lat, SYNC + 1);
    repeat (4) cyc(1'b0, 1'b1);

    // Stall: input held low long enough to hit full scale, then recovery.
    wave(3, 300, 1'b1);
    check("stale_set", stale, 1);
    check("ovf_after_stall", ovf_cnt, 1);
    wave(5, 5, 1'b1);
    check("stale_cleared", stale, 0);
    wave(5, 5, 1'b1);
    check("period_after_stall", period, 10);

    // Rise landing exactly on full-scale count.
    wave(100, 155, 1'b1);
    wave(100, 155, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (SYNC) cyc(1'b1, 1'b1);
    check("period_full_scale", period, MAXC);
    check("no_stale_at_full_scale", stale, 0);
    repeat (20) cyc(1'b0, 1'b1);

    // Enable dropped mid-period, then restored.
    repeat (4) wave(4, 4, 1'b1);
    repeat (2) cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    repeat (3) wave(4, 4, 1'b0);
    check("period_held_while_disabled", period, 8);
    repeat (5) wave(3, 3, 1'b1);
    check("period_after_reenable", period, 6);

    // Randomized periods, occasional stalls and enable drops.
    for (int s = 0; s < 300; s++) begin
      hi = $urandom_range(1, 40);
      lo = ($urandom_range(0, 24) == 0) ? $urandom_range(250, 400) : $urandom_range(1, 40);
      e  = ($urandom_range(0, 19) != 0);
      wave(hi, lo, e);
    end

    // Asynchronous clear in the middle of activity.
    repeat (3) wave(6, 6, 1'b1);
    repeat (3) cyc(1'b1, 1'b1);
    #2 clr = 1'b1;
    #1;
    check("clr_tick", tick, 0);
    check("clr_period", period, 0);
    check("clr_period_vld", period_vld, 0);
    check("clr_stale", stale, 0);
    check("clr_ovf_cnt", ovf_cnt, 0);
    model_reset();
    @(negedge clk);
    clk_in = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) wave(5, 5, 1'b1);
    check("period_after_clr", period, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive end of the team's divided-clock scheme: takes a slow clock (e.g. a divided ~1.5 Hz clock, or any slow external square wave) into the fast clk domain.
- Synchronizes it, emits one-cycle rising-edge ticks, and measures its period in clk cycles, recovering the divide ratio.
- Sits beside the clock divider for self-check and drives LED/7-seg debug logic.

Parameters:
CNT_W, 32, width of period counter and period output (≥4)
SYNC_STAGES, 2, flops in input synchronizer (≥2)

Ports:
clk  input  1  system clock (50 MHz)
clr  input  1  reset, asynchronous, active-high
clk_in  input  1  slow clock to measure, asynchronous to clk
en  input  1  measurement enable, synchronous
tick  output  1  one-clk pulse per synchronized rising edge of clk_in
period  output  CNT_W  last measured period in clk cycles, held between updates
period_vld  output  1  one-clk pulse when period updates
stale  output  1  high while no edge seen for 2^CNT_W-1 cycles
ovf_cnt  output  8  count of stale events, saturates at 255

Behaviour:
- Reset (clr=1, async): all sync flops 0, edge flop 0, tick=0, period=0, period_vld=0, stale=0, ovf_cnt=0, cnt=0, state=IDLE. Reset mid-measurement discards partial count.
- Synchronizer: SYNC_STAGES flops s[0..], plus one history flop h. rise = s[last] & ~h.
- tick is registered: clk_in high first sampled at clk edge k -> tick high for exactly the cycle after edge k+SYNC_STAGES. tick is independent of en and state.
- Minimum resolvable edge spacing: 2 clk cycles. Faster inputs alias; no requirement on them.
- FSM states:
  - IDLE: cnt=0. On rise & en -> MEASURE, cnt<=1.
  - MEASURE: cnt increments each cycle.
    - On rise: period<=cnt, period_vld<=1 same cycle as tick, cnt<=1, stay in MEASURE.
    - When cnt = 2^CNT_W-1 without rise -> STALE; stale<=1; ovf_cnt increments, saturating.
  - STALE: cnt held. On rise -> MEASURE, cnt<=1, stale<=0, no period_vld, period unchanged.
- Period definition: two rises N clk cycles apart give period=N exactly. A steady input toggling every M cycles gives period=2M.
- Simultaneous rise and cnt reaching max in MEASURE: rise wins. period<=max, period_vld pulses, no STALE entry.
- en=0 (any state): next state IDLE, cnt=0, stale<=0. period and ovf_cnt hold; ticks continue. Re-enabling requires a fresh first edge; no period_vld on it.
- Width rules: cnt, period unsigned CNT_W; no wrap, saturation only.

Decomposition:
- Shared package clk_pkg: state encoding localparams (IDLE=2'd0, MEASURE=2'd1, STALE=2'd2), CLK_HZ=50_000_000.
- One natural sub-module: sync_edge (parameterized SYNC_STAGES synchronizer + rising-edge detect), reusable for pushbuttons.
- Counter/FSM stay in clk_period_meter.

Test Plan:
- clr pulse mid-run: all outputs 0 within the same cycle (async). First rise after release produces tick only, no period_vld.
- clk_in toggles every 4 clk, en=1: after first edge, period_vld pulses every 8 cycles with period=8. tick lags clk_in rise by SYNC_STAGES+1 edges.
- Divider-style input: period 2^25 (CNT_W=32) -> period=33554432. Swept to 2^24 -> next update period=16777216.
- CNT_W=8, one edge then clk_in held low: stale rises 255 cycles after MEASURE entry, ovf_cnt=1. Next rise: stale=0, no period_vld. Following rise 10 cycles later: period=10.
- Rise coinciding with cnt=255 (CNT_W=8): period=255, period_vld=1, stale stays 0.
- en dropped mid-period, then raised: no period_vld until two rises after re-enable, ticks uninterrupted, period holds old value.
